// File: rtl/vmul_rr_scheduler_if.sv
// Request/response bundle for vmul_rr_scheduler: NREQ operand ports in,
// one id-tagged 16-bit product out.
interface vmul_rr_scheduler_if #(
  parameter int NREQ = 4
) ();
  localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       rsp_result;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result
  );
endinterface

// File: rtl/vmul_rr_scheduler.sv
// Round-robin scheduler sharing one 8x8 Vedic multiplier among NREQ requesters
// through a 2-stage pipeline. Optional accept counter: VMUL_SCHED_UTIL_CNT_EN.
module vmul_rr_scheduler #(
  parameter int NREQ = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  vmul_rr_scheduler_if.slave  bus
`ifdef VMUL_SCHED_UTIL_CNT_EN
  ,
  output logic [31:0]         util_cnt
`endif
);
  localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  function automatic logic [3:0] vedic2(input logic [1:0] a, input logic [1:0] b);
    logic t, u, c, v;
    t = a[1] & b[0];
    u = a[0] & b[1];
    c = t & u;
    v = a[1] & b[1];
    return {v & c, v ^ c, t ^ u, a[0] & b[0]};
  endfunction

  function automatic logic [7:0] vedic4(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] ll, mid, hh;
    ll  = {4'b0, vedic2(a[1:0], b[1:0])};
    mid = {4'b0, vedic2(a[1:0], b[3:2])} + {4'b0, vedic2(a[3:2], b[1:0])};
    hh  = {4'b0, vedic2(a[3:2], b[3:2])};
    return ll + (mid << 2) + (hh << 4);
  endfunction

  // Urdhva-tiryagbhyam: vertical and crosswise partial products of the halves
  function automatic logic [15:0] vedic8(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] ll, mid, hh;
    ll  = {8'b0, vedic4(a[3:0], b[3:0])};
    mid = {8'b0, vedic4(a[3:0], b[7:4])} + {8'b0, vedic4(a[7:4], b[3:0])};
    hh  = {8'b0, vedic4(a[7:4], b[7:4])};
    return ll + (mid << 4) + (hh << 8);
  endfunction

  logic [7:0]      w_a [NREQ];
  logic [7:0]      w_b [NREQ];
  logic [NREQ-1:0] w_ready;
  logic            w_found;
  logic [IDW-1:0]  w_grant;
  logic [IDW:0]    w_idx;
  logic [IDW-1:0]  w_ptr_next;
  logic            w_s1_en, w_s2_en, w_accept;
  logic [15:0]     w_product;

  logic [IDW-1:0]  r_ptr;
  logic            r_v1, r_v2;
  logic [7:0]      r_a, r_b;
  logic [IDW-1:0]  r_s1_id, r_rsp_id;
  logic [15:0]     r_result;

  assign w_s2_en  = !r_v2 || bus.rsp_ready;
  assign w_s1_en  = !r_v1 || w_s2_en;
  assign w_accept = rst_n && w_found && w_s1_en;

  // First valid requester at or after r_ptr, wrapping modulo NREQ
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = {1'b0, r_ptr} + (IDW+1)'(i);
      if (w_idx >= NREQ_W) w_idx = w_idx - NREQ_W;
      if (!w_found && bus.req_valid[w_idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_idx[IDW-1:0];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign w_a[gi]     = bus.req_a[8*gi +: 8];
      assign w_b[gi]     = bus.req_b[8*gi +: 8];
      assign w_ready[gi] = w_accept && (w_grant == IDW'(gi));
    end
  endgenerate

  assign bus.req_ready = w_ready;
  assign w_ptr_next    = (w_grant == IDW'(NREQ-1)) ? '0 : w_grant + 1'b1;
  assign w_product     = vedic8(r_a, r_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_v1     <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_s1_id  <= '0;
      r_v2     <= 1'b0;
      r_rsp_id <= '0;
      r_result <= '0;
    end else begin
      if (w_s1_en) begin
        r_v1 <= w_accept;
        if (w_accept) begin
          r_a     <= w_a[w_grant];
          r_b     <= w_b[w_grant];
          r_s1_id <= w_grant;
          r_ptr   <= w_ptr_next;
        end
      end
      if (w_s2_en) begin
        r_v2     <= r_v1;
        r_result <= w_product;
        r_rsp_id <= r_s1_id;
      end
    end
  end

  assign bus.rsp_valid  = r_v2;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_result = r_result;

`ifdef VMUL_SCHED_UTIL_CNT_EN
  logic [31:0] r_util_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_util_cnt <= '0;
    else if (w_accept && (r_util_cnt != 32'hFFFF_FFFF))
      r_util_cnt <= r_util_cnt + 32'd1;
  end

  assign util_cnt = r_util_cnt;
`endif
endmodule

// File: tb/tb_vmul_rr_scheduler.sv
// Scoreboard bench for vmul_rr_scheduler: a transaction-level model predicts
// grants, readiness and product timing; a monitor pops and compares responses.
module tb_vmul_rr_scheduler;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vmul_rr_scheduler_if #(.NREQ(NREQ)) bus ();
`ifdef VMUL_SCHED_UTIL_CNT_EN
  logic [31:0] util_cnt;
`endif

  vmul_rr_scheduler #(.NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef VMUL_SCHED_UTIL_CNT_EN
    ,
    .util_cnt (util_cnt)
`endif
  );

  typedef struct {
    int     id;
    int     res;
    longint c0;
  } item_t;

  item_t  q[$];
  int     n_cmp = 0;
  int     n_err = 0;
  int     n_acc = 0;
  int     mptr  = 0;
  longint cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: an accepted item is at the output from the second edge after acceptance
  always @(negedge clk) begin
    bit exp_v;
    if (!rst_n) begin
      chk("rsp_valid_in_reset", longint'(bus.rsp_valid), 0);
    end else begin
      exp_v = (q.size() > 0) && (cyc >= q[0].c0 + 2);
      chk("rsp_valid", longint'(bus.rsp_valid), longint'(exp_v));
      if (exp_v) begin
        chk("rsp_id", longint'(bus.rsp_id), longint'(q[0].id));
        chk("rsp_result", longint'(bus.rsp_result), longint'(q[0].res));
        if (bus.rsp_ready) begin
          $display("rsp id=%0d result=%0d cycle=%0d", bus.rsp_id, bus.rsp_result, cyc);
          void'(q.pop_front());
        end
      end
    end
  end

  // Reference model: round-robin grant from the spec's search rule, capacity of two in flight
  always @(negedge clk) begin
    int g;
    int k;
    int a;
    int b;
    bit cap;
    logic [NREQ-1:0] exp_rdy;
    item_t it;
    #1;
    if (!rst_n) begin
      chk("req_ready_in_reset", longint'(bus.req_ready), 0);
      q.delete();
      mptr  = 0;
      n_acc = 0;
    end else begin
`ifdef VMUL_SCHED_UTIL_CNT_EN
      chk("util_cnt", longint'(util_cnt), longint'(n_acc));
`endif
      g = -1;
      for (int i = 0; i < NREQ; i++) begin
        k = (mptr + i) % NREQ;
        if (g < 0 && bus.req_valid[k]) g = k;
      end
      cap     = (q.size() < 2) || bus.rsp_ready;
      exp_rdy = (g >= 0 && cap) ? (NREQ'(1) << g) : '0;
      chk("req_ready", longint'(bus.req_ready), longint'(exp_rdy));
      if (exp_rdy != '0) begin
        a     = int'(bus.req_a[8*g +: 8]);
        b     = int'(bus.req_b[8*g +: 8]);
        it.id  = g;
        it.res = a * b;
        it.c0  = cyc;
        q.push_back(it);
        mptr = (g + 1) % NREQ;
        n_acc++;
      end
    end
  end

  task automatic drive(input logic [NREQ-1:0] v, input bit rr);
    @(posedge clk);
    #1;
    bus.req_valid = v;
    bus.rsp_ready = rr;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[8*i +: 8] = 8'($urandom);
      bus.req_b[8*i +: 8] = 8'($urandom);
    end
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    bus.req_a[8*i +: 8] = a;
    bus.req_b[8*i +: 8] = b;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst_n         = 1'b0;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.req_valid = '0;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single requester: 3*5, then back-to-back with no bubble
    drive(4'b0001, 1'b1); set_op(0, 8'd3, 8'd5);
    repeat (2) drive(4'b0001, 1'b1);
    repeat (3) drive(4'b0000, 1'b1);

    // operand boundaries on requester 2
    drive(4'b0100, 1'b1); set_op(2, 8'd255, 8'd255);
    drive(4'b0100, 1'b1); set_op(2, 8'd0, 8'd200);
    drive(4'b0100, 1'b1); set_op(2, 8'd200, 8'd0);
    repeat (3) drive(4'b0000, 1'b1);

    // all requesters from ptr=0: rotation 0,1,2,3,0,1,2,3
    pulse_reset();
    repeat (8) drive(4'b1111, 1'b1);
    repeat (3) drive(4'b0000, 1'b1);

    // backpressure for 5 cycles under full traffic
    repeat (3) drive(4'b1111, 1'b1);
    repeat (5) drive(4'b1111, 1'b0);
    repeat (3) drive(4'b1111, 1'b1);
    repeat (4) drive(4'b0000, 1'b1);

    // reset with both stages full, then lowest valid index wins
    repeat (4) drive(4'b1111, 1'b0);
    pulse_reset();
    drive(4'b1010, 1'b1);
    repeat (4) drive(4'b0000, 1'b1);

    // randomized traffic and backpressure
    for (int n = 0; n < 10000; n++) begin
      drive(NREQ'($urandom), ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 499) == 0) pulse_reset();
    end

    drive(4'b0000, 1'b1);
    for (int n = 0; n < 20 && q.size() != 0; n++) @(posedge clk);
    @(negedge clk);
    #2;
    chk("drain_empty", longint'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
